// File: rtl/serial_pkg.sv
// Constants shared by the serial shifter and the serial byte collector.
package serial_pkg;

  localparam int SER_WORD_WIDTH = 8;

  typedef enum logic {
    SER_LSB_FIRST = 1'b0,
    SER_MSB_FIRST = 1'b1
  } ser_bit_order_e;

  // The shifter emits bit 0 first; the collector must reassemble in the same order.
  localparam ser_bit_order_e SER_BIT_ORDER = SER_LSB_FIRST;

endpackage

// File: rtl/serial_bit_counter.sv
// Modulo-WIDTH bit counter with enable and synchronous clear; wrap marks the
// edge on which the last bit of a word is taken.
module serial_bit_counter
  import serial_pkg::*;
#(
  parameter  int WIDTH = SER_WORD_WIDTH,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic          Clock,
  input  logic          reset_b,
  input  logic          enable,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Combinational so the top can capture the completed word on this same edge.
  assign wrap = enable && !clear && (count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge Clock or negedge reset_b) begin
    if (!reset_b) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= wrap ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/serial_byte_collector.sv
// Serial-to-parallel receiver: gathers WIDTH serial bits into a word and offers
// it on data_out with a valid/ack handshake and a sticky overrun flag.
module serial_byte_collector
  import serial_pkg::*;
#(
  parameter  int WIDTH = SER_WORD_WIDTH,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             reset_b,
  input  logic             serial_in,
  input  logic             shift_enable,
  input  logic             clear,
  input  logic             data_ack,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             overrun,
  output logic [CW-1:0]    bit_count
);

  logic             shift_fire;
  logic             word_done;
  logic [WIDTH-2:0] partial;
  logic [WIDTH-1:0] word_next;
  logic [WIDTH-2:0] partial_next;

  assign shift_fire = shift_enable && !clear;

  serial_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .Clock   (Clock),
    .reset_b (reset_b),
    .enable  (shift_fire),
    .clear   (clear),
    .count   (bit_count),
    .wrap    (word_done)
  );

  // Only WIDTH-1 bits are ever held: the final bit of a word goes straight
  // into data_out on the edge it arrives, so it never needs a register of its own.
  if (SER_BIT_ORDER == SER_LSB_FIRST) begin : g_lsb_first
    assign word_next    = {serial_in, partial};
    assign partial_next = word_next[WIDTH-1:1];
  end else begin : g_msb_first
    assign word_next    = {partial, serial_in};
    assign partial_next = word_next[WIDTH-2:0];
  end

  always_ff @(posedge Clock or negedge reset_b) begin
    if (!reset_b) begin
      partial <= '0;
    end else if (clear) begin
      partial <= '0;
    end else if (shift_fire) begin
      partial <= partial_next;
    end
  end

  // An ack in the completion cycle frees the slot, so the new word replaces
  // the old one without an overrun.
  always_ff @(posedge Clock or negedge reset_b) begin
    if (!reset_b) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (word_done && (!data_valid || data_ack)) begin
      data_out   <= word_next;
      data_valid <= 1'b1;
    end else if (data_ack) begin
      data_valid <= 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge reset_b) begin
    if (!reset_b) begin
      overrun <= 1'b0;
    end else if (clear) begin
      overrun <= 1'b0;
    end else if (word_done && data_valid && !data_ack) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_byte_collector.sv
// Directed bench for serial_byte_collector: a per-cycle vector table followed
// by hand-written multi-cycle corner cases.
module tb_serial_byte_collector;

  localparam int WIDTH = 8;
  localparam int CW    = 3;

  typedef struct {
    logic       se;
    logic       si;
    logic       clr;
    logic       ack;
    logic [7:0] exp_out;
    logic       exp_valid;
    logic       exp_ovr;
    logic [2:0] exp_cnt;
  } vec_t;

  logic             Clock;
  logic             reset_b;
  logic             serial_in;
  logic             shift_enable;
  logic             clear;
  logic             data_ack;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             overrun;
  logic [CW-1:0]    bit_count;

  int n_checks = 0;
  int n_pass   = 0;
  vec_t vecs[$];

  serial_byte_collector #(
    .WIDTH (WIDTH)
  ) dut (
    .Clock        (Clock),
    .reset_b      (reset_b),
    .serial_in    (serial_in),
    .shift_enable (shift_enable),
    .clear        (clear),
    .data_ack     (data_ack),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .overrun      (overrun),
    .bit_count    (bit_count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // Outputs are compared as one packed word {data_out, data_valid, overrun, bit_count}.
  function automatic logic [12:0] pack(input logic [7:0] o, input logic v,
                                       input logic ov, input logic [2:0] c);
    return {o, v, ov, c};
  endfunction

  task automatic check(input string name, input logic [12:0] exp);
    logic [12:0] act;
    act = {data_out, data_valid, overrun, bit_count};
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got out=%h valid=%b ovr=%b cnt=%0d, required out=%h valid=%b ovr=%b cnt=%0d",
               name, act[12:5], act[4], act[3], act[2:0], exp[12:5], exp[4], exp[3], exp[2:0]);
    end
  endtask

  task automatic add(input logic se, input logic si, input logic clr, input logic ack,
                     input logic [7:0] o, input logic v, input logic ov, input logic [2:0] c);
    vec_t r;
    r = '{se, si, clr, ack, o, v, ov, c};
    vecs.push_back(r);
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic drive(input logic se, input logic si, input logic clr, input logic ack);
    shift_enable = se;
    serial_in    = si;
    clear        = clr;
    data_ack     = ack;
    @(posedge Clock);
    #1;
    shift_enable = 1'b0;
    serial_in    = 1'b0;
    clear        = 1'b0;
    data_ack     = 1'b0;
  endtask

  task automatic shift_word(input logic [7:0] w, input logic ack_last);
    for (int i = 0; i < 8; i++) drive(1'b1, w[i], 1'b0, ack_last && (i == 7));
  endtask

  initial begin
    // Ack while idle, then 0xA5 LSB first (1,0,1,0,0,1,0,1), then ack.
    add(0, 0, 0, 1, 8'h00, 0, 0, 0);
    add(1, 1, 0, 0, 8'h00, 0, 0, 1);
    add(1, 0, 0, 0, 8'h00, 0, 0, 2);
    add(1, 1, 0, 0, 8'h00, 0, 0, 3);
    add(1, 0, 0, 0, 8'h00, 0, 0, 4);
    add(1, 0, 0, 0, 8'h00, 0, 0, 5);
    add(1, 1, 0, 0, 8'h00, 0, 0, 6);
    add(1, 0, 0, 0, 8'h00, 0, 0, 7);
    add(1, 1, 0, 0, 8'hA5, 1, 0, 0);
    add(0, 0, 0, 1, 8'hA5, 0, 0, 0);
    // 0xFB LSB first (1,1,0,1 | gap x3 | 1,1,1,1), serial_in wiggles in the gap.
    add(1, 1, 0, 0, 8'hA5, 0, 0, 1);
    add(1, 1, 0, 0, 8'hA5, 0, 0, 2);
    add(1, 0, 0, 0, 8'hA5, 0, 0, 3);
    add(1, 1, 0, 0, 8'hA5, 0, 0, 4);
    add(0, 0, 0, 0, 8'hA5, 0, 0, 4);
    add(0, 1, 0, 0, 8'hA5, 0, 0, 4);
    add(0, 0, 0, 0, 8'hA5, 0, 0, 4);
    add(1, 1, 0, 0, 8'hA5, 0, 0, 5);
    add(1, 1, 0, 0, 8'hA5, 0, 0, 6);
    add(1, 1, 0, 0, 8'hA5, 0, 0, 7);
    add(1, 1, 0, 0, 8'hFB, 1, 0, 0);
    add(0, 0, 0, 1, 8'hFB, 0, 0, 0);

    reset_b      = 1'b0;
    serial_in    = 1'b0;
    shift_enable = 1'b0;
    clear        = 1'b0;
    data_ack     = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check("reset_state", pack(8'h00, 0, 0, 0));
    reset_b = 1'b1;
    @(posedge Clock);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].se, vecs[i].si, vecs[i].clr, vecs[i].ack);
      check($sformatf("vec%0d", i),
            pack(vecs[i].exp_out, vecs[i].exp_valid, vecs[i].exp_ovr, vecs[i].exp_cnt));
    end

    // Overrun: second word dropped while the first is unacknowledged.
    shift_word(8'h05, 1'b0);
    check("ovr_first_word", pack(8'h05, 1, 0, 0));
    shift_word(8'h3C, 1'b0);
    check("ovr_dropped", pack(8'h05, 1, 1, 0));
    drive(0, 0, 0, 1);
    check("ovr_after_ack", pack(8'h05, 0, 1, 0));
    drive(0, 0, 1, 0);
    check("ovr_cleared", pack(8'h05, 0, 0, 0));

    // Back-to-back: ack lands on the completion edge of the next word.
    shift_word(8'h11, 1'b0);
    check("b2b_first", pack(8'h11, 1, 0, 0));
    shift_word(8'h22, 1'b1);
    check("b2b_ack_on_done", pack(8'h22, 1, 0, 0));
    drive(0, 0, 0, 1);
    check("b2b_release", pack(8'h22, 0, 0, 0));

    // Clear mid-word discards partial bits and the bit offered with clear.
    for (int i = 0; i < 5; i++) drive(1, 1, 0, 0);
    check("clr_partial", pack(8'h22, 0, 0, 5));
    drive(1, 1, 1, 0);
    check("clr_with_shift", pack(8'h22, 0, 0, 0));
    shift_word(8'h80, 1'b0);
    check("clr_next_word", pack(8'h80, 1, 0, 0));
    drive(0, 0, 0, 1);

    // Async reset between edges with a word valid, overrun set and a partial word.
    shift_word(8'h5A, 1'b0);
    shift_word(8'hFF, 1'b0);
    check("rst_pre_valid", pack(8'h5A, 1, 1, 0));
    drive(1, 1, 0, 0);
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 0);
    check("rst_pre_partial", pack(8'h5A, 1, 1, 3));
    #2 reset_b = 1'b0;
    #1;
    check("rst_async_immediate", pack(8'h00, 0, 0, 0));
    #1 reset_b = 1'b1;
    @(posedge Clock);
    #1;
    shift_word(8'hC3, 1'b0);
    check("rst_then_word", pack(8'hC3, 1, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
